// File: rtl/multicycle_control_fsm_pkg.sv
// Shared constants for the multicycle MIPS control sequencer: opcodes,
// ALU operation codes, datapath mux encodings and controller states.
package ctrl_pkg;

    // Supported IR[31:26] opcodes
    localparam logic [5:0] ALU_R      = 6'h00;
    localparam logic [5:0] JUMP       = 6'h02;
    localparam logic [5:0] BRANCH_EQ  = 6'h04;
    localparam logic [5:0] ADDI       = 6'h08;
    localparam logic [5:0] LOAD_WORD  = 6'h23;
    localparam logic [5:0] STORE_WORD = 6'h2B;

    typedef enum logic [1:0] {
        ADD_OPCODE    = 2'd0,
        SUB_OPCODE    = 2'd1,
        R_TYPE_OPCODE = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_B_REG     = 2'd0,
        SRC_B_FOUR    = 2'd1,
        SRC_B_IMM     = 2'd2,
        SRC_B_IMM_SH2 = 2'd3
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'd0,
        PC_SRC_ALUOUT = 2'd1,
        PC_SRC_JUMP   = 2'd2
    } pc_src_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_EXEC,
        ST_R_WB,
        ST_ADDI_EX,
        ST_ADDI_WB,
        ST_BRANCH,
        ST_JUMP
    } state_e;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Handshake and datapath-control bundle between the control sequencer
// (master) and the datapath / unified memory port (slave).
interface multicycle_control_fsm_if;

    logic       run;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_2_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
    logic       busy;

    modport master (
        input  run, opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, busy
    );

    modport slave (
        output run, opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, busy
    );

endinterface

// File: rtl/multicycle_control_fsm_perf_counter.sv
// Retired-instruction and busy-cycle counters; both wrap modulo 2^CNT_W.
module ctrl_perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             instr_done_i,
    input  logic             busy_i,
    output logic [CNT_W-1:0] instr_count_o,
    output logic [CNT_W-1:0] cycle_count_o
);

    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

    // Increment each counter on its qualifying cycle
    always_comb begin
        instr_count_d = instr_count_q + CNT_W'(instr_done_i);
        cycle_count_d = cycle_count_q + CNT_W'(busy_i);
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            instr_count_q <= '0;
            cycle_count_q <= '0;
        end else begin
            instr_count_q <= instr_count_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign instr_count_o = instr_count_q;
    assign cycle_count_o = cycle_count_q;

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer: walks each instruction through
// FETCH..WB and drives every datapath mux/enable. Optional performance
// counters are built when CTRL_PERF_CNT_EN is defined.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    arst_n,
    multicycle_control_fsm_if.master bus,
    output logic [CNT_W-1:0]        instr_count,
    output logic [CNT_W-1:0]        cycle_count
);

    state_e     state_q, state_d;
    logic [5:0] opcode_q;
    logic       done;
    logic       busy;
    state_e     end_state;

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Opcode is only valid in DECODE; later states use this copy
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)                  opcode_q <= '0;
        else if (state_q == ST_DECODE) opcode_q <= bus.opcode;
    end

    // Next-state and control outputs (Moore per state, Mealy on mem_ready)
    always_comb begin
        state_d           = state_q;
        end_state         = bus.run ? ST_FETCH : ST_IDLE;
        done              = 1'b0;
        busy              = (state_q != ST_IDLE);
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_2_reg     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRC_B_REG;
        bus.alu_op        = ADD_OPCODE;
        bus.pc_source     = PC_SRC_ALU;
        bus.illegal_op    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRC_B_FOUR;
                bus.pc_write  = bus.mem_ready;
                bus.ir_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                bus.alu_src_b = SRC_B_IMM_SH2;
                case (bus.opcode)
                    LOAD_WORD, STORE_WORD: state_d = ST_MEM_ADDR;
                    ALU_R:                 state_d = ST_EXEC;
                    ADDI:                  state_d = ST_ADDI_EX;
                    BRANCH_EQ:             state_d = ST_BRANCH;
                    JUMP:                  state_d = ST_JUMP;
                    default: begin
                        bus.illegal_op = 1'b1;
                        state_d        = end_state;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRC_B_IMM;
                state_d       = (opcode_q == STORE_WORD) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                if (bus.mem_ready) state_d = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                bus.reg_write = 1'b1;
                bus.mem_2_reg = 1'b1;
                done          = 1'b1;
                state_d       = end_state;
            end
            ST_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                done          = bus.mem_ready;
                if (bus.mem_ready) state_d = end_state;
            end
            ST_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = R_TYPE_OPCODE;
                state_d       = ST_R_WB;
            end
            ST_R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                done          = 1'b1;
                state_d       = end_state;
            end
            ST_ADDI_EX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRC_B_IMM;
                state_d       = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                bus.reg_write = 1'b1;
                done          = 1'b1;
                state_d       = end_state;
            end
            ST_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = SUB_OPCODE;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PC_SRC_ALUOUT;
                done              = 1'b1;
                state_d           = end_state;
            end
            ST_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PC_SRC_JUMP;
                done          = 1'b1;
                state_d       = end_state;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.instr_done = done;
    assign bus.busy       = busy;

`ifdef CTRL_PERF_CNT_EN
    ctrl_perf_counter #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk_i        (clk),
        .arst_ni      (arst_n),
        .instr_done_i (done),
        .busy_i       (busy),
        .instr_count_o(instr_count),
        .cycle_count_o(cycle_count)
    );
`else
    assign instr_count = '0;
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-cycle vector table with a scoreboard
// queue, plus a hand-written asynchronous-reset sequence.
module tb_multicycle_control_fsm;

    localparam int unsigned CNT_W = 32;

    // Expected-output word layout:
    // [18] pc_write [17] pc_write_cond [16] i_or_d [15] mem_read [14] mem_write
    // [13] ir_write [12] mem_2_reg [11] reg_dst [10] reg_write [9] alu_src_a
    // [8:7] alu_src_b [6:5] alu_op [4:3] pc_source [2] instr_done [1] illegal_op [0] busy
    localparam logic [18:0] M_PCW  = 19'h40000;
    localparam logic [18:0] M_PCWC = 19'h20000;
    localparam logic [18:0] M_IOD  = 19'h10000;
    localparam logic [18:0] M_MR   = 19'h08000;
    localparam logic [18:0] M_MW   = 19'h04000;
    localparam logic [18:0] M_IRW  = 19'h02000;
    localparam logic [18:0] M_M2R  = 19'h01000;
    localparam logic [18:0] M_RDST = 19'h00800;
    localparam logic [18:0] M_RW   = 19'h00400;
    localparam logic [18:0] M_SA   = 19'h00200;
    localparam logic [18:0] SB1    = 19'h00080;
    localparam logic [18:0] SB2    = 19'h00100;
    localparam logic [18:0] SB3    = 19'h00180;
    localparam logic [18:0] AOPSUB = 19'h00020;
    localparam logic [18:0] AOPR   = 19'h00040;
    localparam logic [18:0] PS1    = 19'h00008;
    localparam logic [18:0] PS2    = 19'h00010;
    localparam logic [18:0] M_DONE = 19'h00004;
    localparam logic [18:0] M_ILL  = 19'h00002;
    localparam logic [18:0] M_BUSY = 19'h00001;

    localparam logic [18:0] E_IDLE   = 19'h0;
    localparam logic [18:0] E_FETCH0 = M_MR | SB1 | M_BUSY;
    localparam logic [18:0] E_FETCH1 = M_MR | SB1 | M_BUSY | M_PCW | M_IRW;
    localparam logic [18:0] E_DEC    = SB3 | M_BUSY;
    localparam logic [18:0] E_DECILL = SB3 | M_BUSY | M_ILL;
    localparam logic [18:0] E_MADDR  = M_SA | SB2 | M_BUSY;
    localparam logic [18:0] E_MRD    = M_MR | M_IOD | M_BUSY;
    localparam logic [18:0] E_MWB    = M_RW | M_M2R | M_DONE | M_BUSY;
    localparam logic [18:0] E_MWR0   = M_MW | M_IOD | M_BUSY;
    localparam logic [18:0] E_MWR1   = M_MW | M_IOD | M_BUSY | M_DONE;
    localparam logic [18:0] E_EXEC   = M_SA | AOPR | M_BUSY;
    localparam logic [18:0] E_RWB    = M_RW | M_RDST | M_DONE | M_BUSY;
    localparam logic [18:0] E_AEX    = M_SA | SB2 | M_BUSY;
    localparam logic [18:0] E_AWB    = M_RW | M_DONE | M_BUSY;
    localparam logic [18:0] E_BR     = M_SA | AOPSUB | M_PCWC | PS1 | M_DONE | M_BUSY;
    localparam logic [18:0] E_JMP    = M_PCW | PS2 | M_DONE | M_BUSY;

    typedef struct {
        logic        run;
        logic [5:0]  op;
        logic        rdy;
        logic [18:0] exp;
    } vec_t;

    logic             clk;
    logic             arst_n;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] cycle_count;

    int unsigned n_pass;
    int unsigned n_total;
    vec_t        vecs[$];
    logic [18:0] exp_q[$];
    logic [63:0] m_instr;
    logic [63:0] m_cycle;

    multicycle_control_fsm_if bus();

    multicycle_control_fsm #(
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .bus        (bus),
        .instr_count(instr_count),
        .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] outs();
        return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.mem_2_reg, bus.reg_dst,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.pc_source, bus.instr_done, bus.illegal_op, bus.busy};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic add(input logic run, input logic [5:0] op, input logic rdy, input logic [18:0] exp);
        vec_t v;
        v.run = run; v.op = op; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Counter expectations: model counts in the performance build, zero otherwise
    task automatic check_counters(input string tag);
`ifdef CTRL_PERF_CNT_EN
        check({tag, "_icnt"}, 64'(instr_count), m_instr & 64'hFFFF_FFFF);
        check({tag, "_ccnt"}, 64'(cycle_count), m_cycle & 64'hFFFF_FFFF);
`else
        check({tag, "_icnt"}, 64'(instr_count), 64'd0);
        check({tag, "_ccnt"}, 64'(cycle_count), 64'd0);
`endif
    endtask

    initial begin
        logic [18:0] e;
        n_pass  = 0;
        n_total = 0;
        m_instr = '0;
        m_cycle = '0;

        // run, opcode, mem_ready, expected outputs for that cycle
        add(0, 6'h00, 1, E_IDLE);
        add(1, 6'h00, 1, E_IDLE);
        // LW, all ready: 5 cycles
        add(1, 6'h00, 1, E_FETCH1);
        add(1, 6'h23, 1, E_DEC);
        add(1, 6'h2B, 1, E_MADDR);   // opcode change after DECODE must be ignored
        add(1, 6'h2B, 1, E_MRD);
        add(1, 6'h00, 1, E_MWB);
        // SW with 3 fetch stalls and 1 write stall
        add(1, 6'h00, 0, E_FETCH0);
        add(1, 6'h00, 0, E_FETCH0);
        add(1, 6'h00, 0, E_FETCH0);
        add(1, 6'h00, 1, E_FETCH1);
        add(1, 6'h2B, 1, E_DEC);
        add(1, 6'h23, 1, E_MADDR);
        add(1, 6'h23, 0, E_MWR0);
        add(1, 6'h23, 1, E_MWR1);
        // BEQ
        add(1, 6'h00, 1, E_FETCH1);
        add(1, 6'h04, 1, E_DEC);
        add(1, 6'h00, 1, E_BR);
        // illegal opcode, continue fetching
        add(1, 6'h00, 1, E_FETCH1);
        add(1, 6'h3F, 1, E_DECILL);
        // ADDI
        add(1, 6'h00, 1, E_FETCH1);
        add(1, 6'h08, 1, E_DEC);
        add(1, 6'h00, 1, E_AEX);
        add(1, 6'h00, 1, E_AWB);
        // J
        add(1, 6'h00, 1, E_FETCH1);
        add(1, 6'h02, 1, E_DEC);
        add(1, 6'h00, 1, E_JMP);
        // LW with a read stall
        add(1, 6'h00, 1, E_FETCH1);
        add(1, 6'h23, 1, E_DEC);
        add(1, 6'h00, 1, E_MADDR);
        add(1, 6'h00, 0, E_MRD);
        add(1, 6'h00, 1, E_MRD);
        add(1, 6'h00, 1, E_MWB);
        // R-type with run dropped in EXEC: completes, then IDLE
        add(1, 6'h00, 1, E_FETCH1);
        add(1, 6'h00, 1, E_DEC);
        add(0, 6'h00, 1, E_EXEC);
        add(0, 6'h00, 1, E_RWB);
        add(0, 6'h00, 1, E_IDLE);
        // illegal opcode with run low goes back to IDLE
        add(1, 6'h00, 1, E_IDLE);
        add(1, 6'h00, 1, E_FETCH1);
        add(0, 6'h11, 1, E_DECILL);
        add(0, 6'h00, 1, E_IDLE);
        add(0, 6'h00, 1, E_IDLE);

        // Reset state
        arst_n        = 1'b0;
        bus.run       = 1'b0;
        bus.opcode    = '0;
        bus.mem_ready = 1'b0;
        #12;
        check("reset_outs", 64'(outs()), 64'd0);
        check_counters("reset");
        @(negedge clk);
        arst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            bus.run       = vecs[i].run;
            bus.opcode    = vecs[i].op;
            bus.mem_ready = vecs[i].rdy;
            exp_q.push_back(vecs[i].exp);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check($sformatf("sb_empty_%0d", i), 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("vec%0d_outs", i), 64'(outs()), 64'(e));
                check_counters($sformatf("vec%0d", i));
                if ((e & M_DONE) != 0) m_instr++;
                if ((e & M_BUSY) != 0) m_cycle++;
            end
        end

        // Asynchronous reset in the middle of a store
        @(posedge clk); #1; bus.run = 1'b1; bus.mem_ready = 1'b1; bus.opcode = 6'h00;  // IDLE
        @(posedge clk); #1;                                                           // FETCH
        @(posedge clk); #1; bus.opcode = 6'h2B;                                       // DECODE
        @(posedge clk); #1;                                                           // MEM_ADDR
        @(posedge clk); #1; bus.mem_ready = 1'b0;                                     // MEM_WR stalled
        #2;
        check("mw_before_rst", 64'(outs()), 64'(E_MWR0));
        #1 arst_n = 1'b0;
        #1;
        check("mw_async_rst", 64'(outs()), 64'd0);
        check_counters_zero();
        #2;
        bus.run = 1'b0;
        arst_n  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_idle%0d", k), 64'(outs()), 64'd0);
        end
        @(posedge clk); #1; bus.run = 1'b1; bus.mem_ready = 1'b1;
        @(negedge clk);
        check("idle_run_hi", 64'(outs()), 64'(E_IDLE));
        @(negedge clk);
        check("fetch_after_rst", 64'(outs()), 64'(E_FETCH1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    task automatic check_counters_zero();
        check("rst_icnt", 64'(instr_count), 64'd0);
        check("rst_ccnt", 64'(cycle_count), 64'd0);
    endtask

endmodule
